// File: rtl/tail_light_input_conditioner.sv
// tail_light_input_conditioner: synchronizes and debounces the brake and turn switches,
//   then resolves them into clean tail-light command levels plus a change strobe.
// Latency: a raw edge held steady appears on the outputs SYNC_STAGES+DEBOUNCE_CYCLES edges later.
// Backpressure: none; free-running, one sample per clock.
//
// Ports:
//   clk, rst                                   - system clock, async active-high reset
//   brake_raw, turn_left_raw, turn_right_raw   - asynchronous bouncing switches
//   brake, turn_left, turn_right, hazard       - registered clean levels
//   change                                     - one-cycle pulse after any output transition
// Optional feature: define TAIL_LIGHT_HAZARD_EN to drive hazard when both turn
//   switches are stably on; otherwise hazard is tied to 0.

module tail_light_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic brake_raw,
  input  logic turn_left_raw,
  input  logic turn_right_raw,
  output logic brake,
  output logic turn_left,
  output logic turn_right,
  output logic hazard,
  output logic change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Channel index: 0 = brake, 1 = turn left, 2 = turn right.
  logic [2:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [2:0]             sample;
  logic [2:0]             stable_q, stable_d;
  logic [CW-1:0]          cnt_q [3];
  logic [CW-1:0]          cnt_d [3];

  logic brake_q, brake_d;
  logic left_q, left_d;
  logic right_q, right_d;
  logic hazard_d;
  logic change_q, change_d;

  assign raw = {turn_right_raw, turn_left_raw, brake_raw};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sample[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Debounce: count consecutive disagreeing samples; an agreeing sample restarts
  // the count. The flip happens on the cycle the count would reach the threshold,
  // so the counter itself never holds DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sample[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Outputs are resolved from the next stable value so the output register
  // updates on the same edge the stable bit flips (no extra cycle of latency).
  always_comb begin
    brake_d  = stable_d[0];
    left_d   = stable_d[1] & ~stable_d[2];
    right_d  = stable_d[2] & ~stable_d[1];
`ifdef TAIL_LIGHT_HAZARD_EN
    hazard_d = stable_d[1] & stable_d[2];
`else
    hazard_d = 1'b0;
`endif
    change_d = ({brake_d, left_d, right_d, hazard_d} != {brake_q, left_q, right_q, hazard});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q <= '0;
      brake_q  <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      stable_q <= stable_d;
      brake_q  <= brake_d;
      left_q   <= left_d;
      right_q  <= right_d;
      change_q <= change_d;
    end
  end

`ifdef TAIL_LIGHT_HAZARD_EN
  logic hazard_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hazard_q <= 1'b0;
    else     hazard_q <= hazard_d;
  end
  assign hazard = hazard_q;
`else
  assign hazard = 1'b0;
`endif

  assign brake      = brake_q;
  assign turn_left  = left_q;
  assign turn_right = right_q;
  assign change     = change_q;

endmodule

// File: tb/tb_tail_light_input_conditioner.sv
// Bench for tail_light_input_conditioner: directed switch scenarios, a per-cycle
// reference model of the conditioning rules, and literal edge-count checks.
module tb_tail_light_input_conditioner;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
`ifdef TAIL_LIGHT_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic brake_raw = 1'b1, turn_left_raw = 1'b1, turn_right_raw = 1'b1;
  logic brake, turn_left, turn_right, hazard, change;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b1;

  tail_light_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .brake_raw(brake_raw), .turn_left_raw(turn_left_raw), .turn_right_raw(turn_right_raw),
    .brake(brake), .turn_left(turn_left), .turn_right(turn_right),
    .hazard(hazard), .change(change)
  );

  always #5 clk = ~clk;

  // Reference model: raw history per channel, stable level flips after DEB
  // consecutive samples that disagree with it.
  logic m_hist [3][SYNC+1];
  logic m_stable [3];
  int   m_run [3];
  logic m_brake, m_left, m_right, m_hazard, m_change;

  always @(posedge clk) begin
    logic rv [3];
    logic nb, nl, nr, nh;
    rv[0] = brake_raw; rv[1] = turn_left_raw; rv[2] = turn_right_raw;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k <= SYNC; k++) m_hist[c][k] = 1'b0;
        m_stable[c] = 1'b0;
        m_run[c] = 0;
      end
      m_brake = 0; m_left = 0; m_right = 0; m_hazard = 0; m_change = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        for (int k = SYNC; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = rv[c];
        if (m_hist[c][SYNC] != m_stable[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_stable[c] = ~m_stable[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      nb = m_stable[0];
      nl = m_stable[1] && !m_stable[2];
      nr = m_stable[2] && !m_stable[1];
      nh = HZ && m_stable[1] && m_stable[2];
      m_change = (nb != m_brake) || (nl != m_left) || (nr != m_right) || (nh != m_hazard);
      m_brake = nb; m_left = nl; m_right = nr; m_hazard = nh;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // Per-cycle model comparison, sampled 1 ns after the rising edge.
  initial begin
    while (run_cmp) begin
      @(posedge clk);
      #1;
      if (run_cmp) begin
        chk("model_brake", brake, m_brake);
        chk("model_turn_left", turn_left, m_left);
        chk("model_turn_right", turn_right, m_right);
        chk("model_hazard", hazard, m_hazard);
        chk("model_change", change, m_change);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held with all raw inputs high: everything stays 0.
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_brake", brake, 1'b0);
      chk("rst_left", turn_left, 1'b0);
      chk("rst_right", turn_right, 1'b0);
      chk("rst_hazard", hazard, 1'b0);
      chk("rst_change", change, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0; brake_raw = 1'b0; turn_left_raw = 1'b0; turn_right_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("release_change", change, 1'b0);
    end

    // Brake press held: output on the 6th edge, change strobe for one cycle.
    @(negedge clk);
    brake_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("brake_latency", brake, (k >= 6) ? 1'b1 : 1'b0);
      chk("brake_change", change, (k == 6) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    brake_raw = 1'b0;
    idle(10);
    chk("brake_released", brake, 1'b0);

    // Left stalk bounce then steady on.
    begin
      logic [4:0] bounce;
      bounce = 5'b01101; // applied LSB first: 1,0,1,1,0
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        turn_left_raw = bounce[k];
        tick();
        chk("bounce_left_low", turn_left, 1'b0);
      end
    end
    @(negedge clk);
    turn_left_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("bounce_left_rise", turn_left, (k == 6) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    turn_left_raw = 1'b0;
    idle(10);
    chk("left_released", turn_left, 1'b0);

    // Short brake glitch of 3 cycles is rejected entirely.
    @(negedge clk);
    brake_raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("glitch_brake", brake, 1'b0);
      chk("glitch_change", change, 1'b0);
    end
    @(negedge clk);
    brake_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_brake", brake, 1'b0);
      chk("glitch_change", change, 1'b0);
    end

    // Both turn stalks on together.
    @(negedge clk);
    turn_left_raw = 1'b1; turn_right_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("both_left", turn_left, 1'b0);
      chk("both_right", turn_right, 1'b0);
      chk("both_hazard", hazard, (k >= 6) ? HZ : 1'b0);
      chk("both_change", change, (k == 6) ? HZ : 1'b0);
    end
    @(negedge clk);
    turn_left_raw = 1'b0; turn_right_raw = 1'b0;
    idle(10);
    chk("both_released_hazard", hazard, 1'b0);

    // Reset during a right-turn debounce discards the partial count.
    @(negedge clk);
    turn_right_raw = 1'b1;
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midrst_right", turn_right, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("midrst_right_rise", turn_right, (k >= 6) ? 1'b1 : 1'b0);
      chk("midrst_change", change, (k == 6) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    turn_right_raw = 1'b0;
    idle(10);

    run_cmp = 1'b0;
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
